// File: rtl/arena_arbiter.sv
// arena_arbiter: owns the single arena row port and arbitrates host (highest), scan and solver access.
// Define ARENA_ARB_OVERRUN_EN to build the sticky step_overrun flag; otherwise step_overrun is tied low.
module arena_arbiter #(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [7:0]             host_row,
  input  logic [ARENA_WIDTH-1:0] host_wdata,
  output logic                   host_ack,
  output logic [ARENA_WIDTH-1:0] host_rdata,
  input  logic                   scan_req,
  output logic                   scan_row_valid,
  output logic [7:0]             scan_row_idx,
  output logic [ARENA_WIDTH-1:0] scan_row_data,
  output logic                   scan_done,
  input  logic                   run_enable,
  input  logic                   step_tick,
  input  logic [31:0]            gens_per_step,
  output logic                   sol_start,
  output logic [31:0]            sol_generations_count,
  input  logic                   sol_ready,
  input  logic [7:0]             sol_row_select,
  input  logic [ARENA_WIDTH-1:0] sol_columns_new,
  input  logic                   sol_columns_write,
  output logic [ARENA_WIDTH-1:0] sol_columns,
  output logic [7:0]             arena_row_select,
  input  logic [ARENA_WIDTH-1:0] arena_columns,
  output logic [ARENA_WIDTH-1:0] arena_columns_new,
  output logic                   arena_columns_write,
  output logic                   step_overrun
);
  typedef enum logic [2:0] {
    S_IDLE, S_HOST, S_HOST_ACK, S_SCAN, S_SOLVE_START, S_SOLVE_RUN
  } state_t;

  localparam logic [7:0] LAST_ROW = 8'(ARENA_HEIGHT - 1);

  state_t     state, state_next;
  logic       scan_pend, scan_again, step_pend, run_first;
  logic [7:0] scan_idx;
  logic       scan_last, host_in_range, busy_solving, tick_ok, tick_accept;

  assign scan_last     = (state == S_SCAN) && (scan_idx == LAST_ROW);
  assign host_in_range = ({1'b0, host_row} < 9'(ARENA_HEIGHT));
  assign busy_solving  = (state == S_SOLVE_START) || (state == S_SOLVE_RUN);
  assign tick_ok       = step_tick && run_enable && (gens_per_step != 32'd0);
  assign tick_accept   = tick_ok && !step_pend && !busy_solving;
  assign sol_columns   = arena_columns;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (host_req)       state_next = S_HOST;
        else if (scan_pend) state_next = S_SCAN;
        else if (step_pend) state_next = S_SOLVE_START;
      end
      S_HOST:        state_next = S_HOST_ACK;
      S_HOST_ACK:    state_next = S_IDLE;
      S_SCAN:        if (scan_idx == LAST_ROW) state_next = S_IDLE;
      S_SOLVE_START: state_next = S_SOLVE_RUN;
      // the solver is still reporting idle on the first run cycle, so ignore it there
      S_SOLVE_RUN:   if (!run_first && sol_ready) state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_comb begin
    arena_row_select    = 8'd0;
    arena_columns_new   = '0;
    arena_columns_write = 1'b0;
    case (state)
      S_HOST: begin
        arena_row_select    = host_row;
        arena_columns_new   = host_wdata;
        arena_columns_write = host_we && host_in_range;
      end
      S_SCAN: arena_row_select = scan_idx;
      S_SOLVE_RUN: begin
        arena_row_select    = sol_row_select;
        arena_columns_new   = sol_columns_new;
        arena_columns_write = sol_columns_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= S_IDLE;
      scan_pend             <= 1'b0;
      scan_again            <= 1'b0;
      step_pend             <= 1'b0;
      run_first             <= 1'b0;
      scan_idx              <= 8'd0;
      host_ack              <= 1'b0;
      host_rdata            <= '0;
      scan_row_valid        <= 1'b0;
      scan_row_idx          <= 8'd0;
      scan_row_data         <= '0;
      scan_done             <= 1'b0;
      sol_start             <= 1'b0;
      sol_generations_count <= 32'd0;
    end else begin
      state          <= state_next;
      host_ack       <= (state == S_HOST);
      sol_start      <= (state_next == S_SOLVE_START);
      run_first      <= (state == S_SOLVE_START);
      scan_row_valid <= (state == S_SCAN);
      scan_done      <= scan_last;
      if (state == S_HOST) host_rdata <= host_in_range ? arena_columns : '0;
      if (state == S_SCAN) begin
        scan_row_idx  <= scan_idx;
        scan_row_data <= arena_columns;
        scan_idx      <= scan_idx + 8'd1;
      end else begin
        scan_idx <= 8'd0;
      end
      // a request landing mid-frame is parked so it survives the end-of-frame clear
      if (scan_last) begin
        scan_pend  <= scan_again || scan_req;
        scan_again <= 1'b0;
      end else if (scan_req) begin
        if (state == S_SCAN) scan_again <= 1'b1;
        else                 scan_pend  <= 1'b1;
      end
      if (state == S_SOLVE_START) begin
        step_pend <= 1'b0;
      end else if (tick_accept) begin
        step_pend             <= 1'b1;
        sol_generations_count <= gens_per_step;
      end
    end
  end

`ifdef ARENA_ARB_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  overrun_q <= 1'b0;
    else if (tick_ok && (step_pend || busy_solving)) overrun_q <= 1'b1;
  end

  assign step_overrun = overrun_q;
`else
  assign step_overrun = 1'b0;
`endif

endmodule
